vend_dispense_arbiter: RTL and testbench
========================================

VEND_DISPENSE_ARBITER -- requirements
Module: vend_dispense_arbiter

Interface
REQ-001 Parameter DISP_CYCLES, default 8: motor-on time per vend in clock cycles; legal range 1..255.
REQ-002 Parameter STOCK_INIT, default 15: per-item stock count loaded at reset and on restock; legal range 1..15.
REQ-003 i_clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 i_resetn  input  1  asynchronous, active-low reset.
REQ-005 i_req  input  4  vend request, one bit per front panel; bit i belongs to requester i.
REQ-006 i_item  input  8  item code per requester in bits [2i+1:2i]; 01/10/11 = item 1/2/3; 00 = invalid.
REQ-007 i_restock  input  1  single-cycle pulse; reloads all stock counters.
REQ-008 o_grant  output  4  one-hot, requester currently owning the dispenser.
REQ-009 o_ack  output  4  one-cycle pulse to the granted requester: vend completed.
REQ-010 o_nack  output  4  one-cycle pulse to the granted requester: vend refused.
REQ-011 o_motor_en  output  1  dispenser motor drive.
REQ-012 o_motor_sel  output  2  item code being dispensed; 00 whenever o_motor_en is low.
REQ-013 o_busy  output  1  high in every state except IDLE.
REQ-014 o_empty  output  3  bit k-1 high when item k stock is zero.

Function
- REQ-015 All outputs are registered; no combinational path from any input to any output.
- REQ-016 States: IDLE, CHECK, DISPENSE, RESP.
- REQ-017 IDLE: if any i_req bit is high, select the winner by round-robin starting at pointer ptr (ptr, ptr+1, ... mod 4), latch winner index and its 2-bit item code, then go to CHECK.
  - If no request is present, remain in IDLE.
- REQ-018 o_grant is high for the winner from the CHECK cycle through the RESP cycle inclusive, and zero in IDLE.
- REQ-019 CHECK, one cycle:
  - If the latched item is 00, or its stock is zero: set a refuse flag and go to RESP.
  - Otherwise: decrement that item's stock by 1, load the duration counter with DISP_CYCLES, and go to DISPENSE.
- REQ-020 DISPENSE:
  - o_motor_en is high and o_motor_sel equals the latched item for exactly DISP_CYCLES consecutive cycles.
  - After the last cycle, go to RESP.
- REQ-021 RESP, one cycle:
  - Pulse o_ack (or o_nack if refused) on the winner bit only.
  - Set ptr to (winner+1) mod 4.
  - Go to IDLE.
- REQ-022 Cycle timing for an accepted request sampled in IDLE at cycle 0:
  - o_grant rises at cycle 1.
  - o_motor_en is high from cycle 2 to cycle 1+DISP_CYCLES.
  - o_ack occurs at cycle 2+DISP_CYCLES.
  - o_grant falls at cycle 3+DISP_CYCLES.
- REQ-023 Timing for a refused request: o_nack occurs at cycle 2, and o_motor_en never rises.
- REQ-024 i_req and i_item are sampled only in IDLE. Changes while busy, including the winner dropping its request, do not abort or alter the transaction.
- REQ-025 A requester holding i_req after its ack/nack is re-arbitrated on the next IDLE cycle, behind the other requesters in rotation.
- REQ-026 Stock counters are 4 bits, saturate at 0, and never wrap.
- REQ-027 i_restock sets all counters to STOCK_INIT. If it coincides with a CHECK decrement, restock wins and the counter equals STOCK_INIT.
- REQ-028 Restock never affects an in-progress dispense or the FSM.
- REQ-029 o_empty[k-1] reflects item k's counter value registered in the same cycle.

Reset
- REQ-030 While i_resetn is low, regardless of clock, all of the following hold:
  - State = IDLE.
  - ptr = 0.
  - o_grant, o_ack, o_nack, o_motor_en, o_motor_sel and o_busy = 0.
  - All stock counters = STOCK_INIT, and o_empty = 0.
- REQ-031 Reset asserted mid-DISPENSE drops o_motor_en immediately. No ack is issued for the aborted vend, and its stock decrement is discarded by the reload.

Configuration
- REQ-032 Macro VEND_STOCK_EN defined: stock counters, o_empty and sold-out refusal exist as specified above.
- REQ-033 VEND_STOCK_EN undefined:
  - No stock counters are built, and i_restock is ignored.
  - o_empty is tied to 000.
  - CHECK refuses only item code 00.

Verification
- REQ-034 Single vend: i_req=0001, item 10, DISP_CYCLES=8 -> grant=0001 at cycle 1; motor_en high cycles 2-9 with motor_sel=10; ack=0001 at cycle 10; item 2 stock 15->14.
- REQ-035 Round-robin: i_req=1111 held continuously -> grants in order 0001, 0010, 0100, 1000, 0001, with no requester granted twice in a row.
- REQ-036 Sold out: STOCK_INIT=1, two requests for item 01 -> first acked; second nacked at cycle 2 with no motor pulse; o_empty=001 after the first vend.
- REQ-037 Invalid item: requester 2 with item 00 -> nack=0100 at cycle 2, motor_en never high, stock unchanged.
- REQ-038 Simultaneous restock: i_restock pulsed in the CHECK cycle of an item-3 vend -> item 3 stock reads 15 afterwards, dispense still completes, ack issued.
- REQ-039 Reset mid-dispense: i_resetn low at cycle 5 of DISPENSE -> motor_en, grant and busy go 0 asynchronously; no ack; all stocks read 15 after release.

Source files
------------

// File: rtl/vend_dispense_arbiter.sv
// vend_dispense_arbiter: round-robin vend arbiter with timed motor drive; define VEND_STOCK_EN to build stock counters and sold-out refusal
module vend_dispense_arbiter #(
  parameter int unsigned DISP_CYCLES = 8,
  parameter int unsigned STOCK_INIT = 15
) (
  input  logic       i_clock,
  input  logic       i_resetn,
  input  logic [3:0] i_req,
  input  logic [7:0] i_item,
  input  logic       i_restock,
  output logic [3:0] o_grant,
  output logic [3:0] o_ack,
  output logic [3:0] o_nack,
  output logic       o_motor_en,
  output logic [1:0] o_motor_sel,
  output logic       o_busy,
  output logic [2:0] o_empty
);
  typedef enum logic [1:0] {IDLE, CHECK, DISPENSE, RESP} state_t;
  state_t state, state_n;
  logic [1:0] ptr, ptr_n, win, win_n, item, item_n, rr;
  logic refuse, refuse_n;
  logic [7:0] cnt, cnt_n;
  logic [3:0] refuse_item;
  // round-robin pick plus next-state and transaction bookkeeping
  always_comb begin
    rr = ptr;
    for (int k = 3; k >= 0; k--) if (i_req[ptr + 2'(k)]) rr = ptr + 2'(k);
    state_n = state;
    ptr_n = ptr;
    win_n = win;
    item_n = item;
    refuse_n = refuse;
    cnt_n = cnt;
    case (state)
      IDLE: if (|i_req) begin
        state_n = CHECK;
        win_n = rr;
        item_n = i_item[2*rr +: 2];
        refuse_n = 1'b0;
      end
      CHECK: begin
        refuse_n = refuse_item[item];
        state_n = refuse_item[item] ? RESP : DISPENSE;
        cnt_n = 8'(DISP_CYCLES);
      end
      DISPENSE: begin
        cnt_n = cnt - 8'd1;
        state_n = (cnt == 8'd1) ? RESP : DISPENSE;
      end
      default: begin
        ptr_n = win + 2'd1;
        state_n = IDLE;
      end
    endcase
  end
  // state and all outputs registered from next-state values
  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      state <= IDLE;
      ptr <= 2'd0;
      win <= 2'd0;
      item <= 2'd0;
      refuse <= 1'b0;
      cnt <= 8'd0;
      o_grant <= 4'd0;
      o_ack <= 4'd0;
      o_nack <= 4'd0;
      o_motor_en <= 1'b0;
      o_motor_sel <= 2'd0;
      o_busy <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      win <= win_n;
      item <= item_n;
      refuse <= refuse_n;
      cnt <= cnt_n;
      o_grant <= (state_n == IDLE) ? 4'd0 : 4'b0001 << win_n;
      o_ack <= (state_n == RESP && !refuse_n) ? 4'b0001 << win_n : 4'd0;
      o_nack <= (state_n == RESP && refuse_n) ? 4'b0001 << win_n : 4'd0;
      o_motor_en <= state_n == DISPENSE;
      o_motor_sel <= (state_n == DISPENSE) ? item_n : 2'd0;
      o_busy <= state_n != IDLE;
    end
  end
`ifdef VEND_STOCK_EN
  logic [3:0] stock [1:3];
  logic [3:0] stock_n [1:3];
  // sold-out flags and counter update; restock overrides a same-cycle decrement
  always_comb begin
    refuse_item = 4'b0001;
    for (int k = 1; k <= 3; k++) begin
      refuse_item[k] = stock[k] == 4'd0;
      stock_n[k] = i_restock ? 4'(STOCK_INIT) : (state == CHECK && item == 2'(k) && stock[k] != 4'd0) ? stock[k] - 4'd1 : stock[k];
    end
  end
  // stock counters and registered empty flags
  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      for (int k = 1; k <= 3; k++) stock[k] <= 4'(STOCK_INIT);
      o_empty <= 3'd0;
    end else begin
      for (int k = 1; k <= 3; k++) stock[k] <= stock_n[k];
      o_empty <= {stock_n[3] == 4'd0, stock_n[2] == 4'd0, stock_n[1] == 4'd0};
    end
  end
`else
  logic unused_restock;
  assign unused_restock = i_restock;
  assign refuse_item = 4'b0001;
  assign o_empty = 3'b000;
`endif
endmodule

// File: tb/tb_vend_dispense_arbiter.sv
// tb_vend_dispense_arbiter: transaction-level reference checks of the vend arbiter
module tb_vend_dispense_arbiter;
  localparam int D = 8;
  localparam int INIT = 15;
  logic clk = 1'b0;
  logic i_resetn;
  logic [3:0] i_req;
  logic [7:0] i_item;
  logic i_restock;
  logic [3:0] o_grant, o_ack, o_nack;
  logic o_motor_en, o_busy;
  logic [1:0] o_motor_sel;
  logic [2:0] o_empty;
  int compared = 0;
  int mismatched = 0;
  int mptr = 0;
  int stock [4];
`ifdef VEND_STOCK_EN
  bit stock_en = 1'b1;
`else
  bit stock_en = 1'b0;
`endif

  vend_dispense_arbiter #(.DISP_CYCLES(D), .STOCK_INIT(INIT)) dut (
    .i_clock(clk), .i_resetn(i_resetn), .i_req(i_req), .i_item(i_item),
    .i_restock(i_restock), .o_grant(o_grant), .o_ack(o_ack), .o_nack(o_nack),
    .o_motor_en(o_motor_en), .o_motor_sel(o_motor_sel), .o_busy(o_busy), .o_empty(o_empty)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [18:0] outs();
    return {o_grant, o_ack, o_nack, o_motor_en, o_motor_sel, o_busy, o_empty};
  endfunction

  function automatic logic [18:0] pack(input logic [3:0] g, a, n, input logic m,
                                       input logic [1:0] s, input logic b, input logic [2:0] e);
    return {g, a, n, m, s, b, e};
  endfunction

  function automatic logic [2:0] mempty();
    logic [2:0] e;
    for (int k = 1; k <= 3; k++) e[k-1] = stock_en && stock[k] == 0;
    return e;
  endfunction

  task automatic model_reload();
    for (int k = 1; k <= 3; k++) stock[k] = INIT;
  endtask

  task automatic chk(input string tag, input logic [18:0] obs, input logic [18:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one arbitration from an IDLE cycle; rs pulses restock in the CHECK cycle
  task automatic txn(input logic [3:0] req, input logic [7:0] item, input bit rs);
    int w, it, len;
    bit refd, m;
    logic [3:0] wb;
    logic [2:0] e0;
    i_req = req;
    i_item = item;
    if (req == 4'd0) begin
      tick();
      chk("idle", outs(), pack(0, 0, 0, 0, 0, 0, mempty()));
      return;
    end
    w = -1;
    for (int k = 0; k < 4; k++) if (w < 0 && req[(mptr + k) % 4]) w = (mptr + k) % 4;
    it = item[2*w +: 2];
    refd = it == 0 || (stock_en && stock[it] == 0);
    wb = 4'b0001 << w;
    e0 = mempty();
    tick();
    i_req = 4'($urandom);
    i_item = 8'($urandom);
    i_restock = rs;
    chk("check", outs(), pack(wb, 0, 0, 0, 0, 1, e0));
    if (stock_en && !refd) stock[it]--;
    if (stock_en && rs) model_reload();
    len = refd ? 2 : 2 + D;
    for (int c = 2; c <= len; c++) begin
      tick();
      i_restock = 1'b0;
      m = !refd && c <= 1 + D;
      chk(refd ? "refuse" : "vend", outs(),
          pack(wb, (c == len && !refd) ? wb : 4'd0, (c == len && refd) ? wb : 4'd0,
               m, m ? 2'(it) : 2'd0, 1, mempty()));
    end
    tick();
    chk("release", outs(), pack(0, 0, 0, 0, 0, 0, mempty()));
    mptr = (w + 1) % 4;
  endtask

  task automatic idle_restock();
    i_req = 4'd0;
    i_restock = 1'b1;
    tick();
    i_restock = 1'b0;
    model_reload();
    chk("restock", outs(), pack(0, 0, 0, 0, 0, 0, mempty()));
  endtask

  initial begin
    logic [7:0] itm;
    model_reload();
    i_resetn = 1'b0;
    i_req = 4'd0;
    i_item = 8'd0;
    i_restock = 1'b0;
    tick();
    tick();
    chk("reset", outs(), 19'd0);
    i_resetn = 1'b1;
    txn(4'b0001, 8'h02, 1'b0);
    txn(4'b0100, 8'h00, 1'b0);
    txn(4'b0000, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      itm = 8'hFF;
      txn(4'b1111, itm, 1'b0);
    end
    txn(4'b0001, 8'h03, 1'b1);
    txn(4'b0010, 8'h0C, 1'b0);
    for (int i = 0; i < 16; i++) txn(4'b0001, 8'h01, 1'b0);
    txn(4'b1000, 8'h40, 1'b0);
    idle_restock();
    for (int i = 0; i < 60; i++) begin
      txn(($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom), 8'($urandom), $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) idle_restock();
    end
    i_req = 4'b0001;
    i_item = 8'h01;
    tick();
    i_req = 4'd0;
    for (int i = 0; i < 5; i++) tick();
    chk("pre_abort", outs(), pack(4'b0001, 0, 0, 1, 2'd1, 1, mempty()));
    #2;
    i_resetn = 1'b0;
    #1;
    chk("async_reset", outs(), 19'd0);
    tick();
    chk("reset_hold", outs(), 19'd0);
    i_resetn = 1'b1;
    mptr = 0;
    model_reload();
    tick();
    chk("after_reset", outs(), 19'd0);
    for (int i = 0; i < 4; i++) txn(4'b0011, 8'h0B, 1'b0);
    for (int i = 0; i < 16; i++) txn(4'b0100, 8'h30, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
